// File: rtl/inst_fetch_axi.sv
// Single-beat AXI4 instruction fetch unit: one outstanding INCR read of a 32-bit word.
// Flushes kill the in-flight fetch while still completing any AXI handshakes already owed.
module inst_fetch_axi #(
  parameter logic [3:0] ARID = 4'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req_i,
  input  logic [31:0] fetch_addr_i,
  input  logic        flush_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o,
  output logic        bus_err_o,
  output logic        stall_req_o,
  output logic [3:0]  arid_o,
  output logic [31:0] araddr_o,
  output logic [7:0]  arlen_o,
  output logic [2:0]  arsize_o,
  output logic [1:0]  arburst_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  input  logic [3:0]  rid_i,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  input  logic        rlast_i,
  input  logic        rvalid_i,
  output logic        rready_o
);

  typedef enum logic [1:0] {StIdle, StAr, StR, StDiscard} state_e;

  state_e state_q;
  logic   flush_seen_q;
  logic   aligned_req;
  logic   unused_r;

  // Only one beat is ever requested, so ID and LAST carry no information.
  assign unused_r = ^{rid_i, rlast_i};

  assign arid_o    = ARID;
  assign arlen_o   = 8'd0;
  assign arsize_o  = 3'b010;
  assign arburst_o = 2'b01;
  assign arvalid_o = (state_q == StAr);
  assign rready_o  = (state_q == StR) || (state_q == StDiscard);

  assign aligned_req = fetch_req_i && !flush_i && (fetch_addr_i[1:0] == 2'b00);

  always_comb begin
    stall_req_o = rst && ((state_q != StIdle) || aligned_req);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      flush_seen_q <= 1'b0;
      araddr_o     <= 32'd0;
      inst_addr_o  <= 32'd0;
      inst_o       <= 32'd0;
      inst_valid_o <= 1'b0;
      bus_err_o    <= 1'b0;
    end else begin
      inst_valid_o <= 1'b0;
      bus_err_o    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (fetch_req_i && !flush_i) begin
            inst_addr_o <= fetch_addr_i;
            if (fetch_addr_i[1:0] == 2'b00) begin
              araddr_o     <= fetch_addr_i;
              flush_seen_q <= 1'b0;
              state_q      <= StAr;
            end else begin
              // Misaligned PC: answer immediately with a zero word, no bus access.
              inst_valid_o <= 1'b1;
              inst_o       <= 32'd0;
            end
          end
        end
        StAr: begin
          if (flush_i) flush_seen_q <= 1'b1;
          if (arready_i) state_q <= (flush_i || flush_seen_q) ? StDiscard : StR;
        end
        StR: begin
          if (rvalid_i) begin
            state_q <= StIdle;
            if (!flush_i) begin
              inst_valid_o <= 1'b1;
              bus_err_o    <= (rresp_i != 2'b00);
              inst_o       <= (rresp_i != 2'b00) ? 32'd0 : rdata_i;
            end
          end else if (flush_i) begin
            state_q <= StDiscard;
          end
        end
        StDiscard: begin
          if (rvalid_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_axi.sv
// Directed bench for inst_fetch_axi: a transaction-level model checked every cycle,
// plus literal expectations pinned to hand-computed scenario timing.
module tb_inst_fetch_axi;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        flush;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        inst_valid;
  logic        bus_err;
  logic        stall;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  inst_fetch_axi #(.ARID(4'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_req_i  (fetch_req),
    .fetch_addr_i (fetch_addr),
    .flush_i      (flush),
    .inst_o       (inst),
    .inst_addr_o  (inst_addr),
    .inst_valid_o (inst_valid),
    .bus_err_o    (bus_err),
    .stall_req_o  (stall),
    .arid_o       (arid),
    .araddr_o     (araddr),
    .arlen_o      (arlen),
    .arsize_o     (arsize),
    .arburst_o    (arburst),
    .arvalid_o    (arvalid),
    .arready_i    (arready),
    .rid_i        (rid),
    .rdata_i      (rdata),
    .rresp_i      (rresp),
    .rlast_i      (rlast),
    .rvalid_i     (rvalid),
    .rready_o     (rready)
  );

  // Transaction-level model: is an address phase owed, is a data beat owed, is it killed.
  bit          m_ar_owed, m_r_owed, m_kill, m_valid, m_err;
  logic [31:0] m_araddr, m_iaddr, m_inst;

  always @(posedge clk) begin
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (!rst) begin
      m_ar_owed = 0; m_r_owed = 0; m_kill = 0;
      m_araddr = 0; m_iaddr = 0; m_inst = 0;
    end else if (m_ar_owed) begin
      if (flush) m_kill = 1;
      if (arready) begin m_ar_owed = 0; m_r_owed = 1; end
    end else if (m_r_owed) begin
      if (flush) m_kill = 1;
      if (rvalid) begin
        m_r_owed = 0;
        if (!m_kill) begin
          m_valid = 1;
          m_err   = (rresp != 2'b00);
          m_inst  = m_err ? 32'd0 : rdata;
        end
      end
    end else if (fetch_req && !flush) begin
      m_iaddr = fetch_addr;
      if (fetch_addr % 4 != 0) begin
        m_valid = 1;
        m_inst  = 32'd0;
      end else begin
        m_araddr  = fetch_addr;
        m_ar_owed = 1;
        m_kill    = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic exp_stall;
    logic [127:0] act_v, exp_v;
    if (chk_en) begin
      exp_stall = rst && (m_ar_owed || m_r_owed || (fetch_req && !flush && fetch_addr % 4 == 0));
      act_v = {arid, arlen, arsize, arburst, arvalid, rready, inst_valid, bus_err, stall,
               araddr, inst_addr, inst};
      exp_v = {4'h0, 8'd0, 3'b010, 2'b01, m_ar_owed, m_r_owed, m_valid, m_err, exp_stall,
               m_araddr, m_iaddr, m_inst};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL model @%0t: got arv=%b rr=%b v=%b err=%b st=%b ara=%h ia=%h i=%h cst=%h/%h/%h/%h, want arv=%b rr=%b v=%b err=%b st=%b ara=%h ia=%h i=%h",
                 $time, arvalid, rready, inst_valid, bus_err, stall, araddr, inst_addr, inst,
                 arid, arlen, arsize, arburst, m_ar_owed, m_r_owed, m_valid, m_err,
                 exp_stall, m_araddr, m_iaddr, m_inst);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic quiet();
    fetch_req = 0; flush = 0; arready = 0; rvalid = 0; rresp = 2'b00;
  endtask

  // Plain fetch: accept, AR handshake next cycle, R beat the cycle after.
  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
    fetch_req = 1; fetch_addr = a; arready = 1;
    tick; fetch_req = 0;
    tick; rvalid = 1; rdata = d; rresp = resp;
    tick; quiet();
  endtask

  initial begin
    rst = 0; fetch_addr = 0; rdata = 0; rid = 4'h5; rlast = 1; quiet();
    tick; chk_en = 1;
    tick; rst = 1;
    samp;
    chk("rst_arvalid", arvalid, 0); chk("rst_inst", inst, 0);
    chk("rst_inst_addr", inst_addr, 0); chk("rst_stall", stall, 0);
    tick;

    // Boot fetch with minimum latency
    fetch_req = 1; fetch_addr = 32'hBFC00000; arready = 1;
    samp; chk("boot_stall_t0", stall, 1);
    tick; fetch_req = 0;
    samp; chk("boot_arvalid", arvalid, 1); chk("boot_araddr", araddr, 32'hBFC00000);
    chk("boot_stall_t1", stall, 1);
    tick; rvalid = 1; rdata = 32'h3C080001; rid = 4'hA;
    samp; chk("boot_rready", rready, 1); chk("boot_stall_t2", stall, 1);
    tick; quiet();
    samp; chk("boot_valid", inst_valid, 1); chk("boot_inst", inst, 32'h3C080001);
    chk("boot_inst_addr", inst_addr, 32'hBFC00000); chk("boot_stall_t3", stall, 0);
    chk("boot_err", bus_err, 0);
    tick;
    samp; chk("boot_pulse_end", inst_valid, 0); chk("boot_hold", inst, 32'h3C080001);
    tick;

    // AR backpressure for five cycles
    fetch_req = 1; fetch_addr = 32'hBFC00010;
    tick; fetch_req = 0;
    for (int i = 0; i < 5; i++) begin
      samp; chk("bp_arvalid", arvalid, 1); chk("bp_araddr", araddr, 32'hBFC00010);
      tick;
    end
    arready = 1;
    tick; arready = 0; rvalid = 1; rdata = 32'h11112222;
    tick; rvalid = 0;
    samp; chk("bp_valid", inst_valid, 1); chk("bp_inst", inst, 32'h11112222);
    tick;

    // Flush while waiting for the R beat, then a clean fetch
    fetch_req = 1; fetch_addr = 32'hBFC00008; arready = 1;
    tick; fetch_req = 0;
    tick; arready = 0; flush = 1;
    tick; flush = 0; rvalid = 1; rdata = 32'h12345678;
    samp; chk("fl_discard_rready", rready, 1);
    tick; rvalid = 0;
    samp; chk("fl_no_valid", inst_valid, 0); chk("fl_idle_stall", stall, 0);
    tick;
    fetch(32'hBFC00004, 32'hAABBCCDD, 2'b00);
    samp; chk("fl_next_valid", inst_valid, 1); chk("fl_next_inst", inst, 32'hAABBCCDD);
    chk("fl_next_addr", inst_addr, 32'hBFC00004);
    tick;

    // Misaligned PC
    fetch_req = 1; fetch_addr = 32'hBFC00002;
    samp; chk("mis_stall", stall, 0);
    tick; fetch_req = 0;
    samp; chk("mis_valid", inst_valid, 1); chk("mis_inst", inst, 0);
    chk("mis_arvalid", arvalid, 0); chk("mis_addr", inst_addr, 32'hBFC00002);
    tick;
    samp; chk("mis_arvalid2", arvalid, 0);
    tick;

    // Error response
    fetch(32'hBFC00040, 32'hDEADBEEF, 2'b10);
    samp; chk("err_valid", inst_valid, 1); chk("err_flag", bus_err, 1); chk("err_inst", inst, 0);
    tick;
    samp; chk("err_pulse_end", bus_err, 0);
    tick;

    // Flush during AR backpressure: AR still completes, beat is dropped
    fetch_req = 1; fetch_addr = 32'hBFC00050;
    tick; fetch_req = 0; flush = 1;
    tick; flush = 0; arready = 1;
    samp; chk("flar_arvalid_held", arvalid, 1);
    tick; arready = 0; rvalid = 1; rdata = 32'h0BADF00D;
    tick; rvalid = 0;
    samp; chk("flar_no_valid", inst_valid, 0);
    tick;

    // Flush in the same cycle as the R handshake
    fetch_req = 1; fetch_addr = 32'hBFC00060; arready = 1;
    tick; fetch_req = 0;
    tick; arready = 0; rvalid = 1; flush = 1; rdata = 32'hCAFEF00D;
    tick; quiet();
    samp; chk("flr_no_valid", inst_valid, 0); chk("flr_idle", rready, 0);
    tick;

    // Flush in IDLE blocks acceptance
    fetch_req = 1; fetch_addr = 32'hBFC00070; flush = 1;
    samp; chk("fli_stall", stall, 0);
    tick; quiet();
    samp; chk("fli_no_ar", arvalid, 0);
    tick;

    // Reset mid-AR, then a stray beat
    fetch_req = 1; fetch_addr = 32'hBFC00020;
    tick; fetch_req = 0; rst = 0;
    samp; chk("rmid_arvalid_pre", arvalid, 1);
    tick; rst = 1;
    samp; chk("rmid_arvalid", arvalid, 0); chk("rmid_araddr", araddr, 0);
    chk("rmid_inst_addr", inst_addr, 0); chk("rmid_inst", inst, 0); chk("rmid_stall", stall, 0);
    tick; rvalid = 1; rdata = 32'h55555555;
    tick; rvalid = 0;
    samp; chk("rmid_late_beat", inst_valid, 0);
    tick;

    fetch(32'hBFC00080, 32'h24020001, 2'b00);
    samp; chk("final_inst", inst, 32'h24020001);
    tick; tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
